instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetch stage of the flow core. Issues word reads to instruction memory, buffers returned 16-bit instructions in a small prefetch queue, and presents them in order with their PC to the decode stage. The decode stage steers bits [11:0] to the unary/ALU decoders. A redirect from execute (branch/jump) flushes all buffered and in-flight fetches and restarts at a new address.

## Interface
- `ADDR_WIDTH`, 16: instruction address width; word-addressed.
- `DEPTH`, 4: prefetch queue entries; power of two, ≥2.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `mem_req` out 1: fetch request valid.
- `mem_addr` out ADDR_WIDTH: request address (= fetch_pc).
- `mem_ready` in 1: memory accepts request this cycle.
- `mem_rvalid` in 1: read data returned; in request order, ≥1 cycle after acceptance.
- `mem_rdata` in 16: returned instruction word.
- `redirect_valid` in 1: flush and restart.
- `redirect_addr` in ADDR_WIDTH: restart address.
- `decode_valid` out 1: queue head is valid.
- `decode_instruction` out 16: queue head instruction.
- `decode_pc` out ADDR_WIDTH: address of the queue head.
- `decode_ready` in 1: decode consumes the head this cycle.

## Operation
- State: `fetch_pc`, `resp_pc`, `outstanding` and `discard` counters (0..DEPTH), queue of {pc, instruction}.
- Credit: `mem_req = !redirect_valid && (occupancy + outstanding < DEPTH)`. The queue can never overflow.
- Request accepted when `mem_req && mem_ready`: `fetch_pc += 1`, `outstanding += 1`.
- Response `mem_rvalid`: `outstanding -= 1`.
  - If `discard > 0`: drop the word and `discard -= 1`.
  - Otherwise push {`resp_pc`, `mem_rdata`} and `resp_pc += 1`.
- Pop when `decode_valid && decode_ready`.
- Redirect (highest priority) takes effect at the next edge:
  - Queue cleared.
  - `fetch_pc` and `resp_pc` set to `redirect_addr`.
  - `discard = outstanding - (mem_rvalid ? 1 : 0)`, counting all surviving in-flight requests.
  - Any pop or push in that cycle is ignored.
  - No request is issued in a redirect cycle.
- `decode_valid` is forced 0 while `redirect_valid` is high.
- Address arithmetic wraps modulo 2^ADDR_WIDTH (0xFFFF+1 → 0x0000).
- Memory must hold `mem_rdata` ordering; no reordering or error path in this block.

## Timing
- Reset values:
  - `fetch_pc = resp_pc = 0`; queue empty; counters 0.
  - `mem_req = 1` in the first cycle after reset release. `mem_addr = 0`.
  - `decode_valid = 0`; `decode_instruction = 0`; `decode_pc = 0`.
- Reset mid-operation drops everything immediately. In-flight responses after release are not tracked; memory must also be reset.
- Latency: response in cycle N → `decode_valid` in cycle N+1 (registered queue, no bypass).
- Push and pop in the same cycle keep occupancy unchanged, including at full.
- Empty plus pop: no-op.
- Throughput: 1 instr/cycle sustained when memory latency + 1 ≤ DEPTH.
- Redirect while `outstanding == 0` sets `discard = 0`. The first post-redirect word is accepted.
- Back-to-back redirects: each recomputes `discard` from current counters; the last address wins.

## Structure
- Shared package `flow_pkg`: `INSTR_WIDTH = 16`, `ADDR_WIDTH` default, and a `fetch_entry_t` {pc, instruction} struct. The decode stage reuses these.
- Sub-module `fetch_queue`: synchronous FIFO, parameterised `DEPTH`/width, with `flush`, `push`, `pop`, `occupancy`, `empty`, `full`.
- Top level holds the PCs, counters, credit and discard logic.

## Test plan
- Reset release with memory at 1-cycle latency returning `mem_rdata = addr ^ 16'hA5A5`, `decode_ready = 1`:
  - `mem_addr` 0,1,2,… on consecutive cycles.
  - `decode_pc` 0,1,2,… with matching data from cycle 3 on.
  - `mem_req` never drops.
- `decode_ready = 0` with memory latency 1:
  - Exactly DEPTH (4) requests issue, then `mem_req = 0`.
  - Queue holds pc 0–3.
  - Raising `decode_ready` resumes at address 4.
- Memory latency 3 with 3 requests in flight; redirect to 0x0100:
  - The three stale responses are dropped.
  - Next `decode_pc` = 0x0100; no stale instruction is ever presented.
- Redirect to 0xFFFE:
  - Decode sees pc 0xFFFE, 0xFFFF, 0x0000 in order.
- Redirect asserted in the same cycle as a response and a pop:
  - The response is dropped and `discard` = outstanding−1.
  - Queue empty next cycle; `decode_valid = 0` during the redirect cycle.
- Assert `rst_n = 0` mid-stream for one cycle:
  - Outputs return to reset values asynchronously.
  - Fetch restarts at address 0.

Source files
------------

// File: rtl/flow_pkg.sv
// Shared fetch/decode types: instruction width, default address width and
// the {pc, instruction} pair that travels from fetch into decode.
package flow_pkg;

  localparam int INSTR_WIDTH = 16;
  localparam int ADDR_WIDTH  = 16;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO for the prefetch queue. Flush empties it at the
// next edge and overrides any push/pop in the same cycle. Push while full
// is accepted only when a pop frees the slot in the same cycle.
module fetch_queue #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    occupancy_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == CW'(DEPTH));
  assign occupancy_o = count_q;
  assign do_pop      = pop_i && !empty_o;
  assign do_push     = push_i && (!full_o || do_pop);
  // Empty queue presents zero so the head outputs are clean out of reset.
  assign rdata_o     = empty_o ? '0 : mem_q[rd_ptr_q];

  // Next pointer/count; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; data words need no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: credit-limited word requests to instruction memory, in-order
// capture of responses into the prefetch queue, and redirect handling that
// discards every response still in flight when the redirect hits.
module instruction_fetch_unit
  import flow_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_ready,
  input  logic                   mem_rvalid,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_addr,
  output logic                   decode_valid,
  output logic [INSTR_WIDTH-1:0] decode_instruction,
  output logic [ADDR_WIDTH-1:0]  decode_pc,
  input  logic                   decode_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_WIDTH + INSTR_WIDTH;

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         discard_q, discard_d;

  logic [CW-1:0] occupancy;
  logic          q_empty, q_full;
  logic [EW-1:0] q_rdata;
  logic [CW:0]   credit_used;
  logic          accept, drop, push, pop;

  // Queue slots plus in-flight requests never exceed DEPTH, so every
  // response always has a slot waiting for it.
  assign credit_used  = {1'b0, occupancy} + {1'b0, outstanding_q};
  assign mem_req      = !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign mem_addr     = fetch_pc_q;
  assign accept       = mem_req && mem_ready;
  assign drop         = mem_rvalid && (discard_q != '0);
  assign push         = mem_rvalid && !drop && !redirect_valid && (!q_full || pop);
  assign decode_valid = !q_empty && !redirect_valid;
  assign pop          = decode_valid && decode_ready;
  assign {decode_pc, decode_instruction} = q_rdata;

  // Next-state for PCs and counters; redirect overrides normal bookkeeping.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CW'(accept) - CW'(mem_rvalid);
    if (redirect_valid) begin
      fetch_pc_d = redirect_addr;
      resp_pc_d  = redirect_addr;
      // Everything still in flight after this cycle's response is stale.
      discard_d  = outstanding_q - CW'(mem_rvalid);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
      if (push)   resp_pc_d  = resp_pc_q + ADDR_WIDTH'(1);
      if (drop)   discard_d  = discard_q - CW'(1);
    end
  end

  // PC and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= '0;
      resp_pc_q     <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .pop_i       (pop),
    .wdata_i     ({resp_pc_q, mem_rdata}),
    .rdata_o     (q_rdata),
    .occupancy_o (occupancy),
    .empty_o     (q_empty),
    .full_o      (q_full)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a latency-configurable memory model and
// an epoch-tagged reference of the fetch stage, driven with random and
// directed stimulus.
module tb_instruction_fetch_unit;
  import flow_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [15:0] addr;
    int          due;
    int          tag;
  } mreq_t;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_addr;
  logic        decode_valid;
  logic [15:0] decode_instruction;
  logic [15:0] decode_pc;
  logic        decode_ready;

  instruction_fetch_unit #(.ADDR_WIDTH(16), .DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .mem_req            (mem_req),
    .mem_addr           (mem_addr),
    .mem_ready          (mem_ready),
    .mem_rvalid         (mem_rvalid),
    .mem_rdata          (mem_rdata),
    .redirect_valid     (redirect_valid),
    .redirect_addr      (redirect_addr),
    .decode_valid       (decode_valid),
    .decode_instruction (decode_instruction),
    .decode_pc          (decode_pc),
    .decode_ready       (decode_ready)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int lat, rdy_pct, drdy_pct, redir_pm;
  bit force_redir;
  logic [15:0] force_addr;

  // Reference state: memory in-flight list, presented queue, fetch address,
  // and a redirect epoch; a response is kept only if its epoch is current.
  mreq_t        memq[$];
  fetch_entry_t mq[$];
  logic [15:0]  m_fetch_pc;
  int           epoch;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    memq.delete();
    mq.delete();
    m_fetch_pc = 16'h0000;
    epoch      = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the reference, then
  // advance the reference and the clock.
  task automatic step();
    bit    exp_req, exp_dv, have_r;
    mreq_t r;
    mem_ready      = ($urandom_range(99) < rdy_pct);
    decode_ready   = ($urandom_range(99) < drdy_pct);
    redirect_valid = force_redir || ($urandom_range(999) < redir_pm);
    if (force_redir)                redirect_addr = force_addr;
    else if ($urandom_range(3) == 0) redirect_addr = 16'hFFFC + 16'($urandom_range(3));
    else                            redirect_addr = 16'($urandom);
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = memq[0].addr ^ 16'hA5A5;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 16'($urandom);
    end
    #1;
    exp_req = !redirect_valid && ((mq.size() + memq.size()) < DEPTH);
    exp_dv  = (mq.size() > 0) && !redirect_valid;
    check_eq("mem_req", 32'(mem_req), 32'(exp_req));
    if (exp_req) check_eq("mem_addr", 32'(mem_addr), 32'(m_fetch_pc));
    check_eq("decode_valid", 32'(decode_valid), 32'(exp_dv));
    if (exp_dv) begin
      check_eq("decode_pc", 32'(decode_pc), 32'(mq[0].pc));
      check_eq("decode_instr", 32'(decode_instruction), 32'(mq[0].instruction));
    end
    have_r = mem_rvalid;
    if (have_r) r = memq.pop_front();
    if (redirect_valid) begin
      mq.delete();
      m_fetch_pc = redirect_addr;
      epoch++;
    end else begin
      if (exp_dv && decode_ready) void'(mq.pop_front());
      if (have_r && r.tag == epoch)
        mq.push_back('{pc: r.addr, instruction: r.addr ^ 16'hA5A5});
      if (exp_req && mem_ready) begin
        memq.push_back('{addr: m_fetch_pc, due: cyc + lat, tag: epoch});
        m_fetch_pc = m_fetch_pc + 16'h0001;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic redirect_to(input logic [15:0] a);
    force_redir = 1'b1;
    force_addr  = a;
    step();
    force_redir = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    redirect_valid = 1'b0; redirect_addr = '0; decode_ready = 1'b0;
    lat = 1; rdy_pct = 100; drdy_pct = 100; redir_pm = 0;
    force_redir = 1'b0; force_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_decode_valid", 32'(decode_valid), 32'd0);
    check_eq("rst_decode_instr", 32'(decode_instruction), 32'd0);
    check_eq("rst_decode_pc", 32'(decode_pc), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;

    // Streaming at one-cycle latency, decode always ready.
    repeat (20) step();

    // Decode stalled: queue fills, requests stop, then resume.
    drdy_pct = 0;
    repeat (10) step();
    check_eq("stall_req_low", 32'(mem_req), 32'd0);
    drdy_pct = 100;
    repeat (10) step();

    // Three-cycle latency with requests in flight, then redirect.
    lat = 3;
    repeat (6) step();
    redirect_to(16'h0100);
    repeat (15) step();

    // Address wrap after redirect near the top.
    redirect_to(16'hFFFE);
    repeat (12) step();

    // Redirect coinciding with a response and a pop.
    lat = 1;
    repeat (5) step();
    redirect_to(16'h0040);
    repeat (8) step();

    // Back-to-back redirects; the last address wins.
    lat = 2;
    repeat (4) step();
    redirect_to(16'h0200);
    redirect_to(16'h0300);
    repeat (10) step();

    // Asynchronous reset mid-stream.
    rst_n = 1'b0;
    mem_rvalid = 1'b0; redirect_valid = 1'b0;
    #1;
    check_eq("async_rst_valid", 32'(decode_valid), 32'd0);
    check_eq("async_rst_pc", 32'(decode_pc), 32'd0);
    check_eq("async_rst_instr", 32'(decode_instruction), 32'd0);
    check_eq("async_rst_addr", 32'(mem_addr), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
    lat = 1;
    repeat (10) step();

    // Randomized traffic across latencies with occasional redirects.
    for (int ph = 0; ph < 8; ph++) begin
      lat      = int'($urandom_range(4, 1));
      rdy_pct  = 70;
      drdy_pct = 60;
      redir_pm = 30;
      repeat (250) step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
